// File: rtl/id_stage_pipe.sv
// Decode stage: GPR file with WB write port and same-cycle bypass, R/I/J field split,
// per-opcode immediate extension, load-use bubble insertion, valid/ready output register.
module id_stage_pipe #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int RAW   = $clog2(NREGS),
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic             wb_en,
   input  logic [RAW-1:0]   wb_addr,
   input  logic [XLEN-1:0]  wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       opcode,
   output logic [RAW-1:0]   rs_addr,
   output logic [RAW-1:0]   rt_addr,
   output logic [XLEN-1:0]  rs_data,
   output logic [XLEN-1:0]  rt_data,
   output logic [RAW-1:0]   rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [XLEN-1:0]  imm,
   output logic [CNT_W-1:0] decoded_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] ins);
      logic [XLEN-1:0] res;
      case (ins[31:26])
         OP_RTYPE:                res = '0;
         OP_ANDI, OP_ORI, OP_XORI: res = XLEN'(ins[15:0]);
         OP_LUI:                  res = XLEN'({ins[15:0], 16'h0000});
         OP_J, OP_JAL:            res = XLEN'(ins[25:0]);
         default:                 res = {{(XLEN-16){ins[15]}}, ins[15:0]};
      endcase
      return res;
   endfunction

   logic [XLEN-1:0]  r_gpr [NREGS];
   logic             r_out_valid;
   logic [5:0]       r_opcode;
   logic [RAW-1:0]   r_rs_addr;
   logic [RAW-1:0]   r_rt_addr;
   logic [XLEN-1:0]  r_rs_data;
   logic [XLEN-1:0]  r_rt_data;
   logic [RAW-1:0]   r_rd;
   logic [4:0]       r_shamt;
   logic [5:0]       r_funct;
   logic [XLEN-1:0]  r_imm;
   logic [CNT_W-1:0] r_decoded_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   logic [5:0]       w_op;
   logic [RAW-1:0]   w_rs_a;
   logic [RAW-1:0]   w_rt_a;
   logic             w_is_r;
   logic [XLEN-1:0]  w_rs_data;
   logic [XLEN-1:0]  w_rt_data;
   logic             w_rt_is_src;
   logic             w_hazard;
   logic             w_accept;

   assign w_op   = instr[31:26];
   assign w_rs_a = RAW'(instr[25:21]);
   assign w_rt_a = RAW'(instr[20:16]);
   assign w_is_r = (w_op == OP_RTYPE);

   // Read ports: r0 is hard zero, an in-flight WB write to the same register wins.
   always_comb begin
      w_rs_data = r_gpr[w_rs_a];
      w_rt_data = r_gpr[w_rt_a];
      if (wb_en && wb_addr == w_rs_a) w_rs_data = wb_data;
      if (wb_en && wb_addr == w_rt_a) w_rt_data = wb_data;
      if (w_rs_a == '0) w_rs_data = '0;
      if (w_rt_a == '0) w_rt_data = '0;
   end

   // rt is a true source only for R-type, stores and compare-branches.
   assign w_rt_is_src = (w_op == OP_RTYPE) || (w_op == OP_SW) ||
                        (w_op == OP_BEQ)   || (w_op == OP_BNE);

   assign w_hazard = r_out_valid && (r_opcode == OP_LW) && (r_rt_addr != '0) &&
                     ((r_rt_addr == w_rs_a) || ((r_rt_addr == w_rt_a) && w_rt_is_src));

   assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
         r_out_valid   <= 1'b0;
         r_opcode      <= '0;
         r_rs_addr     <= '0;
         r_rt_addr     <= '0;
         r_rs_data     <= '0;
         r_rt_data     <= '0;
         r_rd          <= '0;
         r_shamt       <= '0;
         r_funct       <= '0;
         r_imm         <= '0;
         r_decoded_cnt <= '0;
         r_bubble_cnt  <= '0;
      end else begin
         if (wb_en && wb_addr != '0) r_gpr[wb_addr] <= wb_data;

         if (r_out_valid && out_ready) r_decoded_cnt <= r_decoded_cnt + 1'b1;

         // Output register stage: load, bubble, drain, or hold.
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_opcode    <= w_op;
            r_rs_addr   <= w_rs_a;
            r_rt_addr   <= w_rt_a;
            r_rs_data   <= w_rs_data;
            r_rt_data   <= w_rt_data;
            r_rd        <= w_is_r ? RAW'(instr[15:11]) : '0;
            r_shamt     <= w_is_r ? instr[10:6] : 5'd0;
            r_funct     <= w_is_r ? instr[5:0] : 6'd0;
            r_imm       <= ext_imm(instr);
         end else if (w_hazard && out_ready) begin
            r_out_valid  <= 1'b0;
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign opcode      = r_opcode;
   assign rs_addr     = r_rs_addr;
   assign rt_addr     = r_rt_addr;
   assign rs_data     = r_rs_data;
   assign rt_data     = r_rt_data;
   assign rd          = r_rd;
   assign shamt       = r_shamt;
   assign funct       = r_funct;
   assign imm         = r_imm;
   assign decoded_cnt = r_decoded_cnt;
   assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: GPR/bypass, immediates, load-use bubble, stall and reset.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  opcode;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [31:0] imm;
   logic [15:0] decoded_cnt;
   logic [15:0] bubble_cnt;

   int checks = 0;
   int errors = 0;
   int exp_dec = 0;

   id_stage_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data), .rd(rd), .shamt(shamt), .funct(funct),
      .imm(imm), .decoded_cnt(decoded_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; instr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h exp 0", out_valid); end
      checks++; if (decoded_cnt !== 16'd0) begin errors++; $display("FAIL rst_dec: got %0h exp 0", decoded_cnt); end
      checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL rst_bub: got %0h exp 0", bubble_cnt); end
      checks++; if ({rs_data, rt_data, imm} !== 96'd0) begin errors++; $display("FAIL rst_data: got %0h exp 0", {rs_data, rt_data, imm}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0h exp 1", in_ready); end
   endtask

   task automatic test_wb_read();
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
      tick();
      wb_en = 1'b0;
      instr = {6'h00, 5'd5, 5'd0, 5'd9, 5'd3, 6'h20};
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; instr = '0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wb_valid: got %0h exp 1", out_valid); end
      checks++; if (rs_data !== 32'h0000_1234) begin errors++; $display("FAIL wb_rs_data: got %0h exp 1234", rs_data); end
      checks++; if ({rd, shamt, funct} !== {5'd9, 5'd3, 6'h20}) begin errors++; $display("FAIL wb_rfields: got %0h exp %0h", {rd, shamt, funct}, {5'd9, 5'd3, 6'h20}); end
      tick();
      exp_dec++;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wb_drain: got %0h exp 0", out_valid); end
      checks++; if (decoded_cnt !== 16'(exp_dec)) begin errors++; $display("FAIL wb_dec: got %0d exp %0d", decoded_cnt, exp_dec); end
   endtask

   task automatic test_bypass();
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_CAFE;
      instr = {6'h00, 5'd0, 5'd7, 5'd1, 5'd0, 6'h21};
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0; instr = '0; out_ready = 1'b0;
      wb_data = 32'h0000_BEEF;
      checks++; if (rt_data !== 32'h0000_CAFE) begin errors++; $display("FAIL byp_rt_data: got %0h exp cafe", rt_data); end
      tick();
      wb_en = 1'b0;
      checks++; if (rt_data !== 32'h0000_CAFE) begin errors++; $display("FAIL byp_hold_data: got %0h exp cafe", rt_data); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_hold_valid: got %0h exp 1", out_valid); end
      out_ready = 1'b1;
      tick();
      exp_dec++;
      // r7 now holds BEEF from the write during the hold
      instr = {6'h00, 5'd7, 5'd0, 5'd2, 5'd0, 6'h20};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0; instr = '0;
      checks++; if (rs_data !== 32'h0000_BEEF) begin errors++; $display("FAIL byp_later_write: got %0h exp beef", rs_data); end
      tick();
      exp_dec++;
   endtask

   task automatic test_r0();
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_FFFF;
      tick();
      wb_data = 32'h0000_5555;
      instr = {6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20};
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      wb_en = 1'b0; in_valid = 1'b0; instr = '0;
      checks++; if ({rs_data, rt_data} !== 64'd0) begin errors++; $display("FAIL r0_read: got %0h exp 0", {rs_data, rt_data}); end
      tick();
      exp_dec++;
   endtask

   task automatic test_imm();
      out_ready = 1'b1; in_valid = 1'b1;
      instr = {6'h0D, 5'd0, 5'd1, 16'h8001};
      tick();
      checks++; if (imm !== 32'h0000_8001) begin errors++; $display("FAIL imm_ori: got %0h exp 8001", imm); end
      checks++; if ({rd, shamt, funct} !== 16'd0) begin errors++; $display("FAIL imm_ori_rfields: got %0h exp 0", {rd, shamt, funct}); end
      instr = {6'h08, 5'd0, 5'd1, 16'h8001};
      tick();
      exp_dec++;
      checks++; if (imm !== 32'hFFFF_8001) begin errors++; $display("FAIL imm_addi: got %0h exp ffff8001", imm); end
      instr = {6'h0F, 5'd0, 5'd1, 16'h1234};
      tick();
      exp_dec++;
      checks++; if (imm !== 32'h1234_0000) begin errors++; $display("FAIL imm_lui: got %0h exp 12340000", imm); end
      instr = {6'h02, 26'h3AB_CDEF};
      tick();
      exp_dec++;
      checks++; if (imm !== 32'h03AB_CDEF) begin errors++; $display("FAIL imm_j: got %0h exp 3abcdef", imm); end
      in_valid = 1'b0; instr = '0;
      tick();
      exp_dec++;
      checks++; if (decoded_cnt !== 16'(exp_dec)) begin errors++; $display("FAIL imm_dec: got %0d exp %0d", decoded_cnt, exp_dec); end
   endtask

   task automatic test_load_use();
      out_ready = 1'b1; in_valid = 1'b1;
      instr = {6'h23, 5'd0, 5'd3, 16'h0004};
      tick();
      checks++; if (opcode !== 6'h23 || imm !== 32'h4) begin errors++; $display("FAIL lu_lw: got %0h/%0h exp 23/4", opcode, imm); end
      instr = {6'h00, 5'd3, 5'd0, 5'd10, 5'd0, 6'h20};
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready: got %0h exp 0", in_ready); end
      tick();
      exp_dec++;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0h exp 0", out_valid); end
      checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_bub_cnt: got %0d exp 1", bubble_cnt); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_after: got %0h exp 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || rd !== 5'd10 || rs_addr !== 5'd3) begin errors++; $display("FAIL lu_add_follows: got %0h/%0d/%0d exp 1/10/3", out_valid, rd, rs_addr); end
      instr = {6'h23, 5'd0, 5'd4, 16'h0000};
      tick();
      exp_dec++;
      // I-type ALU reads only rs, so a matching rt is not a hazard
      instr = {6'h08, 5'd0, 5'd4, 16'h0001};
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_itype_rt: got %0h exp 1", in_ready); end
      tick();
      exp_dec++;
      checks++; if (opcode !== 6'h08 || bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_no_bubble: got %0h/%0d exp 8/1", opcode, bubble_cnt); end
      instr = {6'h23, 5'd0, 5'd6, 16'h0000};
      tick();
      exp_dec++;
      instr = {6'h2B, 5'd0, 5'd6, 16'h0000};
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_sw_rt: got %0h exp 0", in_ready); end
      tick();
      exp_dec++;
      tick();
      in_valid = 1'b0; instr = '0;
      checks++; if (opcode !== 6'h2B || bubble_cnt !== 16'd2) begin errors++; $display("FAIL lu_sw_follows: got %0h/%0d exp 2b/2", opcode, bubble_cnt); end
      tick();
      exp_dec++;
      checks++; if (decoded_cnt !== 16'(exp_dec)) begin errors++; $display("FAIL lu_dec: got %0d exp %0d", decoded_cnt, exp_dec); end
   endtask

   task automatic test_stall_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      instr = {6'h00, 5'd5, 5'd0, 5'd9, 5'd0, 6'h20};
      tick();
      instr = {6'h0D, 5'd0, 5'd1, 16'h00FF};
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL st_in_ready%0d: got %0h exp 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || rs_data !== 32'h1234 || funct !== 6'h20) begin errors++; $display("FAIL st_hold%0d: got %0h/%0h/%0h exp 1/1234/20", i, out_valid, rs_data, funct); end
         checks++; if (decoded_cnt !== 16'(exp_dec)) begin errors++; $display("FAIL st_dec%0d: got %0d exp %0d", i, decoded_cnt, exp_dec); end
         tick();
      end
      rst = 1'b1; in_valid = 1'b0; instr = '0;
      tick();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0 || decoded_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin errors++; $display("FAIL st_rst_ctl: got %0h/%0d/%0d exp 0/0/0", out_valid, decoded_cnt, bubble_cnt); end
      checks++; if ({opcode, rs_data, funct, imm} !== 76'd0) begin errors++; $display("FAIL st_rst_data: got %0h exp 0", {opcode, rs_data, funct, imm}); end
      out_ready = 1'b1; in_valid = 1'b1;
      instr = {6'h00, 5'd5, 5'd7, 5'd9, 5'd0, 6'h20};
      tick();
      in_valid = 1'b0; instr = '0;
      checks++; if ({rs_data, rt_data} !== 64'd0) begin errors++; $display("FAIL st_rst_gpr: got %0h exp 0", {rs_data, rt_data}); end
      tick();
   endtask

   initial begin
      test_reset();
      test_wb_read();
      test_bypass();
      test_r0();
      test_imm();
      test_load_use();
      test_stall_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
